// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt front-end: bridge word offsets,
// default source count and the CP0 HWInt bit the sources start at.
package irq_ctrl_pkg;

  localparam int N_SRC_DEF  = 6;
  localparam int HWINT_BASE = 2;

  typedef enum logic [1:0] {
    IRQ_PEND  = 2'd0,
    IRQ_MASK  = 2'd1,
    IRQ_MODE  = 2'd2,
    IRQ_CAUSE = 2'd3
  } irq_word_e;

endpackage

// File: rtl/irq_sync.sv
// Single-bit synchroniser: STAGES flops, cleared asynchronously by reset=0.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front-end: synchronise and edge-detect the external lines,
// latch pending requests, mask and prioritise them for CP0.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int               N_SRC       = N_SRC_DEF,
  parameter int               SYNC_STAGES = 2,
  parameter logic [N_SRC-1:0] MASK_RST    = 6'h3f,
  parameter logic [N_SRC-1:0] MODE_RST    = 6'h3f
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [N_SRC-1:0] hwint,
  output logic             irq_req,
  output logic [2:0]       irq_id,
  input  logic             irq_ack
);

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] s_d_reg;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_sel;
  logic [N_SRC-1:0] pend_reg, pend_next;
  logic [N_SRC-1:0] mask_reg;
  logic [N_SRC-1:0] mode_reg;
  logic             w1c;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:N_SRC];
  assign w1c          = we && (addr == IRQ_PEND);
  assign rise         = s & ~s_d_reg;

  // Edge-mode bits: a rise beats any clear arriving in the same cycle.
  // Level-mode bits simply mirror the synchronised line.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq_in[gi]),
      .q     (s[gi])
    );

    assign ack_sel[gi]   = irq_ack && irq_req && (irq_id == 3'(gi));
    assign pend_next[gi] = mode_reg[gi]
                         ? (rise[gi] | (pend_reg[gi] & ~((w1c & wdata[gi]) | ack_sel[gi])))
                         : s[gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_d_reg  <= '0;
      pend_reg <= '0;
      mask_reg <= MASK_RST;
      mode_reg <= MODE_RST;
    end else begin
      s_d_reg  <= s;
      pend_reg <= pend_next;
      if (we && (addr == IRQ_MASK)) mask_reg <= wdata[N_SRC-1:0];
      if (we && (addr == IRQ_MODE)) mode_reg <= wdata[N_SRC-1:0];
    end
  end

  assign hwint   = pend_reg & mask_reg;
  assign irq_req = |hwint;

  // Lowest index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    irq_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (hwint[i]) irq_id = 3'(i);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      IRQ_PEND:  rdata = {{(32-N_SRC){1'b0}}, pend_reg};
      IRQ_MASK:  rdata = {{(32-N_SRC){1'b0}}, mask_reg};
      IRQ_MODE:  rdata = {{(32-N_SRC){1'b0}}, mode_reg};
      IRQ_CAUSE: rdata = {irq_req, 28'b0, irq_id};
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register table, directed corner sequences and a
// randomized run against a queue-based behavioural model.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          we = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wdata = '0;
  logic          irq_ack = 1'b0;
  logic [31:0]   rdata;
  logic [N-1:0]  hwint;
  logic          irq_req;
  logic [2:0]    irq_id;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .hwint   (hwint),
    .irq_req (irq_req),
    .irq_id  (irq_id),
    .irq_ack (irq_ack)
  );

  int checks = 0;
  int errors = 0;

  // Model: hist[0] is irq_in as sampled at the most recent edge, so the
  // synchronised value is hist[1] and its one-cycle-old copy is hist[2].
  logic [N-1:0] m_pend, m_mask, m_mode;
  logic [N-1:0] hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int m_lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    logic [N-1:0] hw;
    hw = m_pend & m_mask;
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(m_mode);
      default: return {(hw != '0), 28'b0, 3'(m_lowest(hw))};
    endcase
  endfunction

  task automatic m_clear();
    m_pend = '0;
    m_mask = 6'h3f;
    m_mode = 6'h3f;
    hist.delete();
    repeat (3) hist.push_back('0);
  endtask

  task automatic m_step();
    logic [N-1:0] s, sd, rise, hw, np;
    logic         req;
    int           id;
    if (!reset) begin
      m_clear();
      return;
    end
    s    = hist[1];
    sd   = hist[2];
    rise = s & ~sd;
    hw   = m_pend & m_mask;
    req  = (hw != '0);
    id   = m_lowest(hw);
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i])
        np[i] = s[i];
      else
        np[i] = rise[i] ||
                (m_pend[i] && !((we && addr == IRQ_PEND && wdata[i]) || (irq_ack && req && id == i)));
    end
    if (we && addr == IRQ_MASK) m_mask = wdata[N-1:0];
    if (we && addr == IRQ_MODE) m_mode = wdata[N-1:0];
    m_pend = np;
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endtask

  task automatic compare();
    logic [N-1:0] hw;
    hw = m_pend & m_mask;
    check("mdl_hwint", 32'(hwint), 32'(hw));
    check("mdl_irq_req", 32'(irq_req), 32'(hw != '0));
    check("mdl_irq_id", 32'(irq_id), 32'(m_lowest(hw)));
    check("mdl_rdata", rdata, m_rdata(addr));
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic ncycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    $display("irq_ctrl bench: sources map to HWInt[%0d:%0d]", HWINT_BASE + N - 1, HWINT_BASE);

    // Reset defaults while lines are all high
    m_clear();
    irq_in = 6'h3f;
    ncycles(3);
    check("rst_hwint", 32'(hwint), 32'h0);
    check("rst_req", 32'(irq_req), 32'h0);
    reset = 1'b1;
    irq_in = '0;
    rd_check("rst_mask", 2'd1, 32'h3f);
    rd_check("rst_mode", 2'd2, 32'h3f);
    rd_check("rst_pend", 2'd0, 32'h0);
    ncycles(3);

    // Register table: write, then read back
    vecs[0] = '{2'd1, 32'h0000002a, 2'd1, 32'h0000002a};
    vecs[1] = '{2'd1, 32'hffffffc5, 2'd1, 32'h00000005};
    vecs[2] = '{2'd2, 32'h00000015, 2'd2, 32'h00000015};
    vecs[3] = '{2'd3, 32'hffffffff, 2'd3, 32'h00000000};
    vecs[4] = '{2'd0, 32'h0000003f, 2'd0, 32'h00000000};
    vecs[5] = '{2'd1, 32'h0000003f, 2'd1, 32'h0000003f};
    vecs[6] = '{2'd2, 32'h0000003f, 2'd2, 32'h0000003f};
    for (int v = 0; v < 7; v++) begin
      wr(vecs[v].waddr, vecs[v].wdata);
      rd_check($sformatf("vec%0d", v), vecs[v].raddr, vecs[v].exp);
      $display("vec %0d: wr[%0d]=0x%08h rd[%0d]=0x%08h", v, vecs[v].waddr, vecs[v].wdata,
               vecs[v].raddr, rdata);
    end

    // Edge capture and latency
    irq_in = 6'h01;
    cycle(); check("edge_lat1", 32'(irq_req), 32'h0);
    cycle(); check("edge_lat2", 32'(irq_req), 32'h0);
    cycle(); check("edge_lat3", 32'(irq_req), 32'h1);
    ncycles(3);
    irq_in = '0;
    ncycles(3);
    rd_check("edge_pend", 2'd0, 32'h01);
    ack_pulse();
    check("edge_ack_req", 32'(irq_req), 32'h0);
    rd_check("edge_ack_pend", 2'd0, 32'h0);
    $display("seq edge: done");

    // Priority between two simultaneous sources
    irq_in = 6'h0a;
    ncycles(2);
    irq_in = '0;
    ncycles(3);
    check("prio_id1", 32'(irq_id), 32'd1);
    ack_pulse();
    check("prio_id3", 32'(irq_id), 32'd3);
    check("prio_req3", 32'(irq_req), 32'h1);
    ack_pulse();
    check("prio_done", 32'(irq_req), 32'h0);
    $display("seq prio: done");

    // Mask and level mode
    wr(2'd1, 32'h3e);
    wr(2'd2, 32'h3e);
    irq_in = 6'h01;
    ncycles(4);
    rd_check("lvl_pend0", 2'd0, 32'h01);
    check("lvl_masked", 32'(hwint), 32'h0);
    irq_in = '0;
    ncycles(3);
    wr(2'd2, 32'h3a);
    irq_in = 6'h04;
    ncycles(3);
    check("lvl_hw2", 32'(hwint), 32'h04);
    check("lvl_id2", 32'(irq_id), 32'd2);
    ack_pulse();
    check("lvl_ack_kept", 32'(hwint), 32'h04);
    irq_in = '0;
    ncycles(2);
    check("lvl_hold2", 32'(hwint), 32'h04);
    cycle();
    check("lvl_clr3", 32'(hwint), 32'h0);
    $display("seq level: done");

    // Rise vs W1C in the same cycle, ack with nothing requested
    wr(2'd2, 32'h3f);
    wr(2'd1, 32'h3f);
    irq_in = 6'h10;
    ncycles(2);
    we = 1'b1; addr = 2'd0; wdata = 32'h10;
    cycle();
    we = 1'b0;
    rd_check("conf_set_wins", 2'd0, 32'h10);
    irq_in = '0;
    wr(2'd1, 32'h0);
    check("conf_noreq", 32'(irq_req), 32'h0);
    ack_pulse();
    rd_check("ack_noreq", 2'd0, 32'h10);
    wr(2'd0, 32'h10);
    rd_check("w1c_clear", 2'd0, 32'h0);
    wr(2'd1, 32'h3f);
    $display("seq conflict: done");

    // Reset mid-pulse with the line still high afterwards
    irq_in = 6'h20;
    ncycles(4);
    rd_check("pre_rst", 2'd0, 32'h20);
    reset = 1'b0;
    m_clear();
    #1;
    rd_check("rst_at_once", 2'd0, 32'h0);
    check("rst_hw_once", 32'(hwint), 32'h0);
    ncycles(2);
    reset = 1'b1;
    ncycles(2);
    rd_check("rel_2", 2'd0, 32'h0);
    cycle();
    rd_check("rel_3", 2'd0, 32'h20);
    irq_in = '0;
    wr(2'd0, 32'h3f);
    ncycles(3);
    $display("seq reset: done");

    // Randomized run against the model
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (6'(1) << $urandom_range(0, 5));
      we      = ($urandom_range(0, 5) == 0);
      addr    = 2'($urandom_range(0, 3));
      wdata   = $urandom;
      irq_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        m_clear();
      end else begin
        reset = 1'b1;
      end
      cycle();
      $display("rnd %0d: irq_in=%02h we=%0d addr=%0d ack=%0d rst=%0d -> hwint=%02h req=%0d id=%0d",
               t, irq_in, we, addr, irq_ack, reset, hwint, irq_req, irq_id);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
